// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// mode-qualified rise/fall pulse, sticky flag and saturating event counter.
module edge_detector_bank #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 1,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       sig_in,
   input  logic [2*WIDTH-1:0]     mode,
   input  logic [WIDTH-1:0]       clr,
   input  logic                   cnt_clr,
   output logic [WIDTH-1:0]       level,
   output logic [WIDTH-1:0]       pulse,
   output logic [WIDTH-1:0]       sticky,
   output logic                   any_evt,
   output logic [WIDTH*CNT_W-1:0] evt_cnt
);

   localparam int DC_W = $clog2(DEBOUNCE) + 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic             sy;
      logic             level_q, level_d;
      logic [DC_W-1:0]  dc_q, dc_d;
      logic             pulse_q, pulse_d;
      logic             sticky_q, sticky_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             rise, fall, qual;

      // With zero stages the input is trusted to be synchronous already.
      if (SYNC_STAGES > 0) begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q, sync_d;

         always_comb begin
            sync_d[0] = sig_in[i];
            for (int k = 1; k < SYNC_STAGES; k++) begin
               sync_d[k] = sync_q[k-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q <= sync_d;
            end
         end

         assign sy = sync_q[SYNC_STAGES-1];
      end else begin : g_nosync
         assign sy = sig_in[i];
      end

      always_comb begin
         level_d = level_q;
         dc_d    = '0;
         if (sy != level_q) begin
            if (dc_q == DC_LAST) begin
               level_d = sy;
            end else begin
               dc_d = dc_q + DC_W'(1);
            end
         end
      end

      // Edges are taken from the accepted level transition, so the pulse
      // lands on the same edge as the new level.
      always_comb begin
         rise = level_d & ~level_q;
         fall = ~level_d & level_q;
         qual = (rise & mode[2*i]) | (fall & mode[2*i+1]);
      end

      always_comb begin
         pulse_d  = qual;
         sticky_d = qual | (sticky_q & ~clr[i]);
         cnt_d    = cnt_q;
         if (cnt_clr) begin
            cnt_d = qual ? CNT_W'(1) : '0;
         end else if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            level_q  <= 1'b0;
            dc_q     <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            level_q  <= level_d;
            dc_q     <= dc_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
         end
      end

      assign level[i]                  = level_q;
      assign pulse[i]                  = pulse_q;
      assign sticky[i]                 = sticky_q;
      assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
   end

   assign any_evt = |sticky;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Drives two edge_detector_bank configurations with directed and random
// stimulus and compares every output against a history-based reference model.
module tb_edge_detector_bank;

   localparam int MAXE = 4096;

   logic       clk;
   logic       rstV;
   logic [3:0] sigV;
   logic [7:0] modeV;
   logic [3:0] clrV;
   logic       ccV;

   logic [3:0]  levelA, pulseA, stickyA, levelB, pulseB, stickyB;
   logic        anyA, anyB;
   logic [7:0]  cntA;
   logic [31:0] cntB;

   int nChecks = 0;
   int nPass   = 0;
   int nFail   = 0;

   // Reference model state: raw input history plus per-instance outputs.
   int         nEdge = 0;
   int         lastRst = 0;
   logic [3:0] sigHist [MAXE];
   bit         rstHist [MAXE];
   logic [3:0] mLevel  [2];
   logic [3:0] mPulse  [2];
   logic [3:0] mSticky [2];
   int         mCnt    [2][4];

   edge_detector_bank #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rstV), .sig_in(sigV), .mode(modeV), .clr(clrV), .cnt_clr(ccV),
      .level(levelA), .pulse(pulseA), .sticky(stickyA), .any_evt(anyA), .evt_cnt(cntA)
   );

   edge_detector_bank #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rstV), .sig_in(sigV), .mode(modeV), .clr(clrV), .cnt_clr(ccV),
      .level(levelB), .pulse(pulseB), .sticky(stickyB), .any_evt(anyB), .evt_cnt(cntB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int debOf(int n);
      return (n == 0) ? 4 : 1;
   endfunction

   function automatic int cntMaxOf(int n);
      return (n == 0) ? 3 : 255;
   endfunction

   // Synchronised value seen by the filter at edge k: the input sampled two
   // edges earlier, forced low if either of the intervening edges was a reset.
   function automatic logic syAt(int k, int ch);
      if (k < 2) return 1'b0;
      if (rstHist[k-1] || rstHist[k-2]) return 1'b0;
      return sigHist[k-2][ch];
   endfunction

   task automatic modelStep();
      int  k;
      int  d;
      bit  acc, rise, fall, qual;
      logic v;
      k = nEdge;
      sigHist[k] = sigV;
      rstHist[k] = rstV;
      if (rstV) begin
         lastRst = k;
         for (int n = 0; n < 2; n++) begin
            mLevel[n]  = '0;
            mPulse[n]  = '0;
            mSticky[n] = '0;
            for (int ch = 0; ch < 4; ch++) mCnt[n][ch] = 0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            d = debOf(n);
            for (int ch = 0; ch < 4; ch++) begin
               v   = ~mLevel[n][ch];
               acc = ((k - lastRst) >= d);
               for (int j = k - d + 1; j <= k; j++) begin
                  if (syAt(j, ch) !== v) acc = 0;
               end
               rise = acc && (v == 1'b1);
               fall = acc && (v == 1'b0);
               if (acc) mLevel[n][ch] = v;
               qual = (rise && modeV[2*ch]) || (fall && modeV[2*ch+1]);
               mPulse[n][ch] = qual;
               if (qual) mSticky[n][ch] = 1'b1;
               else if (clrV[ch]) mSticky[n][ch] = 1'b0;
               if (ccV) mCnt[n][ch] = qual ? 1 : 0;
               else if (qual && (mCnt[n][ch] < cntMaxOf(n))) mCnt[n][ch]++;
            end
         end
      end
      nEdge++;
   endtask

   task automatic checkValue(string tag, logic [31:0] observed, logic [31:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else begin
         nFail++;
         $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, nEdge, observed, expected);
      end
   endtask

   task automatic checkOutput();
      checkValue("a.level",  32'(levelA),  32'(mLevel[0]));
      checkValue("a.pulse",  32'(pulseA),  32'(mPulse[0]));
      checkValue("a.sticky", 32'(stickyA), 32'(mSticky[0]));
      checkValue("a.any",    32'(anyA),    32'(|mSticky[0]));
      checkValue("b.level",  32'(levelB),  32'(mLevel[1]));
      checkValue("b.pulse",  32'(pulseB),  32'(mPulse[1]));
      checkValue("b.sticky", 32'(stickyB), 32'(mSticky[1]));
      checkValue("b.any",    32'(anyB),    32'(|mSticky[1]));
      for (int ch = 0; ch < 4; ch++) begin
         checkValue($sformatf("a.cnt%0d", ch), 32'(cntA[ch*2 +: 2]), 32'(mCnt[0][ch]));
         checkValue($sformatf("b.cnt%0d", ch), 32'(cntB[ch*8 +: 8]), 32'(mCnt[1][ch]));
      end
   endtask

   task automatic applyStimulus();
      if (nEdge >= MAXE) begin
         $display("[TB] FAIL history overflow edge=%0d limit=%0d", nEdge, MAXE);
         $fatal(1, "[TB] history overflow");
      end
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      rstV  = 1'b1;
      sigV  = 4'h0;
      modeV = 8'h55;
      clrV  = 4'h0;
      ccV   = 1'b0;
      @(negedge clk);
      repeat (2) applyStimulus();
      rstV = 1'b0;
      repeat (3) applyStimulus();

      // Single rising edge on channel 0.
      sigV[0] = 1'b1;
      repeat (8) applyStimulus();

      // Short glitch then a long pulse on channel 1.
      sigV[1] = 1'b1;
      repeat (3) applyStimulus();
      sigV[1] = 1'b0;
      repeat (8) applyStimulus();
      sigV[1] = 1'b1;
      repeat (6) applyStimulus();
      sigV[1] = 1'b0;
      repeat (10) applyStimulus();

      // Channel 2 in both-edge mode, then fall-only mode.
      modeV[5:4] = 2'b11;
      sigV[2] = 1'b1; repeat (8) applyStimulus();
      sigV[2] = 1'b0; repeat (8) applyStimulus();
      sigV[2] = 1'b1; repeat (8) applyStimulus();
      modeV[5:4] = 2'b10;
      sigV[2] = 1'b0; repeat (8) applyStimulus();
      sigV[2] = 1'b1; repeat (8) applyStimulus();
      sigV[2] = 1'b0; repeat (8) applyStimulus();

      // Sticky clear coinciding with, then following, a qualified edge on ch3.
      clrV = 4'hF;
      applyStimulus();
      sigV[3] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         clrV = (i == 2 || i == 3 || i == 5 || i == 6) ? 4'b1000 : 4'b0000;
         applyStimulus();
      end
      clrV = 4'h0;

      // Counter saturation on channel 0, then clear with a coincident edge.
      modeV[1:0] = 2'b11;
      for (int e = 0; e < 5; e++) begin
         sigV[0] = ~sigV[0];
         repeat (7) applyStimulus();
      end
      sigV[0] = ~sigV[0];
      for (int i = 0; i < 8; i++) begin
         ccV = (i == 2 || i == 5);
         applyStimulus();
      end
      ccV = 1'b0;

      // Reset while channel 1 is part-way through its debounce window.
      sigV[1] = 1'b1;
      repeat (4) applyStimulus();
      rstV = 1'b1;
      applyStimulus();
      rstV = 1'b0;
      repeat (10) applyStimulus();

      // Random traffic on all channels.
      for (int t = 0; t < 1500; t++) begin
         rstV = ($urandom_range(0, 399) == 0);
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 5) == 0) sigV[ch] = ~sigV[ch];
         end
         if ($urandom_range(0, 49) == 0) modeV = 8'($urandom);
         clrV = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
         ccV  = ($urandom_range(0, 99) == 0);
         applyStimulus();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
